mmio_out_port: RTL and testbench

- Memory-mapped output port on the chipset memory bus, downstream of the CPU/memory path.
- Snoops CPU bus writes to PORT_ADDR and queues them in a small FIFO.
- Presents queued values on OUT with a valid/ready handshake; OUT is a display latch between transfers.
- Exposes a status word (overflow flag, occupancy) for the CPU read mux at STATUS_ADDR.

---
 rtl/mmio_out_port_pkg.sv | 25 ++
 rtl/mmio_out_port_fifo.sv | 56 +++++
 rtl/mmio_out_port.sv | 105 ++++++++++
 tb/tb_mmio_out_port.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_out_port_pkg.sv
// Shared chipset types: bus word, memory command flags, output-port FSM states,
// and the I/O addresses claimed by the memory-mapped output port.
`ifndef TYPEDEF_COLLECTION_DEFINES
`define TYPEDEF_COLLECTION_DEFINES
`define REGSIZE 8
`define IO_PORT_ADDR 8'hFF
`define IO_STATUS_ADDR 8'hFE
`endif

package typedef_collection;

  typedef logic [`REGSIZE-1:0] DEFAULT_TYPE;

  typedef enum logic [1:0] {
    MEMORY_NOP   = 2'd0,
    MEMORY_READ  = 2'd1,
    MEMORY_WRITE = 2'd2
  } MEMORY_FLAG_TYPE;

  typedef enum logic {
    OUT_PORT_IDLE    = 1'b0,
    OUT_PORT_PRESENT = 1'b1
  } OUT_PORT_STATE_TYPE;

endpackage

// File: rtl/mmio_out_port_fifo.sv
// Small synchronous FIFO of bus words. The head is visible combinationally;
// a push while full is only taken when a pop frees a slot in the same cycle.
module sync_fifo
  import typedef_collection::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     pop,
  input  DEFAULT_TYPE              data_in,
  output DEFAULT_TYPE              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  DEFAULT_TYPE       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign head  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/mmio_out_port.sv
// Memory-mapped output port: snoops CPU writes to PORT_ADDR into a FIFO and
// presents them on OUT with a valid/ready handshake. OUT keeps the last word
// shown after the handshake completes. status_data reports {overflow, count}.
module mmio_out_port
  import typedef_collection::*;
#(
  parameter DEFAULT_TYPE PORT_ADDR   = `IO_PORT_ADDR,
  parameter DEFAULT_TYPE STATUS_ADDR = `IO_STATUS_ADDR,
  parameter int          DEPTH       = 4
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            enable,
  input  DEFAULT_TYPE     addr_bus,
  input  DEFAULT_TYPE     write_bus,
  input  MEMORY_FLAG_TYPE ctrl_bus,
  output DEFAULT_TYPE     OUT,
  output logic            out_valid,
  input  logic            out_ready,
  output DEFAULT_TYPE     status_data
);

  localparam int CW = $clog2(DEPTH) + 1;

  OUT_PORT_STATE_TYPE state;
  OUT_PORT_STATE_TYPE state_next;

  logic           push_req;
  logic           clr_req;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  DEFAULT_TYPE    fifo_head;
  logic           overflow;

  // Bus decode: capture and overflow clear only while the CPU owns the bus.
  assign push_req = enable & (ctrl_bus == MEMORY_WRITE) & (addr_bus == PORT_ADDR);
  assign clr_req  = enable & (ctrl_bus == MEMORY_WRITE) & (addr_bus == STATUS_ADDR);

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .push    (push_req),
    .pop     (pop),
    .data_in (write_bus),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Handshake FSM state register.
  always_ff @(posedge CLOCK) begin
    if (RESET) state <= OUT_PORT_IDLE;
    else       state <= state_next;
  end

  // Next state: enter PRESENT when a word is loaded, leave once accepted with nothing queued.
  always_comb begin
    state_next = state;
    case (state)
      OUT_PORT_IDLE:    if (!fifo_empty) state_next = OUT_PORT_PRESENT;
      OUT_PORT_PRESENT: if (out_ready && fifo_empty) state_next = OUT_PORT_IDLE;
      default:          state_next = OUT_PORT_IDLE;
    endcase
  end

  // FSM outputs: pop when OUT is free (idle) or is being accepted this cycle.
  always_comb begin
    out_valid = 1'b0;
    pop       = 1'b0;
    case (state)
      OUT_PORT_IDLE: begin
        pop = ~fifo_empty;
      end
      OUT_PORT_PRESENT: begin
        out_valid = 1'b1;
        pop       = out_ready & ~fifo_empty;
      end
      default: begin
        out_valid = 1'b0;
        pop       = 1'b0;
      end
    endcase
  end

  // Display latch: loads the FIFO head on every pop, otherwise holds.
  always_ff @(posedge CLOCK) begin
    if (RESET)    OUT <= '0;
    else if (pop) OUT <= fifo_head;
  end

  // Sticky overflow on a dropped push; a drop in the same cycle beats a clear.
  always_ff @(posedge CLOCK) begin
    if (RESET)                               overflow <= 1'b0;
    else if (push_req && fifo_full && !pop)  overflow <= 1'b1;
    else if (clr_req)                        overflow <= 1'b0;
  end

  assign status_data = DEFAULT_TYPE'({overflow, fifo_count});

endmodule

// File: tb/tb_mmio_out_port.sv
// Self-checking bench for mmio_out_port: directed scenarios plus a random run,
// all checked against a queue-based behavioural model of the port.
module tb_mmio_out_port;
  import typedef_collection::*;

  localparam int DEPTH = 4;
  localparam DEFAULT_TYPE PADDR = 8'hFF;
  localparam DEFAULT_TYPE SADDR = 8'hFE;

  logic            CLOCK = 1'b0;
  logic            RESET;
  logic            enable;
  DEFAULT_TYPE     addr_bus;
  DEFAULT_TYPE     write_bus;
  MEMORY_FLAG_TYPE ctrl_bus;
  DEFAULT_TYPE     OUT;
  logic            out_valid;
  logic            out_ready;
  DEFAULT_TYPE     status_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  DEFAULT_TYPE mq[$];
  DEFAULT_TYPE m_out;
  logic        m_vld;
  logic        m_ov;

  mmio_out_port #(
    .PORT_ADDR   (PADDR),
    .STATUS_ADDR (SADDR),
    .DEPTH       (DEPTH)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .enable      (enable),
    .addr_bus    (addr_bus),
    .write_bus   (write_bus),
    .ctrl_bus    (ctrl_bus),
    .OUT         (OUT),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .status_data (status_data)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic DEFAULT_TYPE m_status();
    return DEFAULT_TYPE'(mq.size() + (m_ov ? 8 : 0));
  endfunction

  // One clock edge of the port as described behaviourally.
  task automatic model_step();
    logic preq, clr, pop;
    if (RESET) begin
      mq.delete();
      m_out = '0;
      m_vld = 1'b0;
      m_ov  = 1'b0;
    end else begin
      preq = enable && ctrl_bus == MEMORY_WRITE && addr_bus == PADDR;
      clr  = enable && ctrl_bus == MEMORY_WRITE && addr_bus == SADDR;
      pop  = mq.size() > 0 && (!m_vld || out_ready);
      if (pop) begin
        m_out = mq.pop_front();
        m_vld = 1'b1;
      end else if (m_vld && out_ready) begin
        m_vld = 1'b0;
      end
      if (clr) m_ov = 1'b0;
      if (preq) begin
        if (mq.size() < DEPTH) mq.push_back(write_bus);
        else m_ov = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic en, input DEFAULT_TYPE a, input DEFAULT_TYPE w,
                       input MEMORY_FLAG_TYPE c, input logic rdy);
    enable    = en;
    addr_bus  = a;
    write_bus = w;
    ctrl_bus  = c;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    drive(1'b0, 8'h00, 8'h00, MEMORY_NOP, 1'b0);
    tick();
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (OUT !== 8'h00 || out_valid !== 1'b0 || status_data !== 8'h00) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got OUT=%h v=%b st=%h want OUT=00 v=0 st=00",
                 i, OUT, out_valid, status_data);
      end
    end
  endtask

  task automatic test_single();
    drive(1'b1, PADDR, 8'h2A, MEMORY_WRITE, 1'b0);
    tick();
    total++;
    if (out_valid !== 1'b0 || status_data !== 8'h01) begin
      bad++;
      $display("FAIL single_push_edge got v=%b st=%h want v=0 st=01", out_valid, status_data);
    end
    drive(1'b1, 8'h10, 8'h00, MEMORY_NOP, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (OUT !== 8'h2A || out_valid !== 1'b1 || status_data !== 8'h00) begin
        bad++;
        $display("FAIL single_present cyc=%0d got OUT=%h v=%b st=%h want OUT=2a v=1 st=00",
                 i, OUT, out_valid, status_data);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (OUT !== 8'h2A || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_accept got OUT=%h v=%b want OUT=2a v=0", OUT, out_valid);
    end
  endtask

  task automatic test_stream();
    DEFAULT_TYPE got[$];
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, PADDR, DEFAULT_TYPE'(i), MEMORY_WRITE, 1'b1);
      tick();
      if (out_valid) got.push_back(OUT);
      total++;
      if ({OUT, out_valid, status_data} !== {m_out, m_vld, m_status()}) begin
        bad++;
        $display("FAIL stream_fill cyc=%0d got OUT=%h v=%b st=%h want OUT=%h v=%b st=%h",
                 i, OUT, out_valid, status_data, m_out, m_vld, m_status());
      end
    end
    drive(1'b1, 8'h00, 8'h00, MEMORY_NOP, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) got.push_back(OUT);
    end
    total++;
    if (got.size() != 4 || got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3 || got[3] !== 8'd4) begin
      bad++;
      $display("FAIL stream_order got n=%0d %p want 1,2,3,4", got.size(), got);
    end
    total++;
    if (out_valid !== 1'b0 || status_data !== 8'h00 || OUT !== 8'd4) begin
      bad++;
      $display("FAIL stream_end got OUT=%h v=%b st=%h want OUT=04 v=0 st=00",
               OUT, out_valid, status_data);
    end
  endtask

  task automatic test_overflow();
    DEFAULT_TYPE got[$];
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, PADDR, DEFAULT_TYPE'(i), MEMORY_WRITE, 1'b0);
      tick();
      total++;
      if ({OUT, out_valid, status_data} !== {m_out, m_vld, m_status()}) begin
        bad++;
        $display("FAIL ovf_fill cyc=%0d got OUT=%h v=%b st=%h want OUT=%h v=%b st=%h",
                 i, OUT, out_valid, status_data, m_out, m_vld, m_status());
      end
    end
    total++;
    if (status_data !== 8'h0C || OUT !== 8'd1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL ovf_status got OUT=%h v=%b st=%h want OUT=01 v=1 st=0c",
               OUT, out_valid, status_data);
    end
    drive(1'b1, 8'h00, 8'h00, MEMORY_NOP, 1'b1);
    got.push_back(OUT);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) got.push_back(OUT);
    end
    total++;
    if (got.size() != 5 || got[0] !== 8'd1 || got[4] !== 8'd5 || status_data !== 8'h08) begin
      bad++;
      $display("FAIL ovf_drain got n=%0d %p st=%h want 1..5 st=08", got.size(), got, status_data);
    end
    drive(1'b1, SADDR, 8'h00, MEMORY_WRITE, 1'b0);
    tick();
    total++;
    if (status_data !== 8'h00) begin
      bad++;
      $display("FAIL ovf_clear got st=%h want st=00", status_data);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, PADDR, DEFAULT_TYPE'(8'h10 + i), MEMORY_WRITE, 1'b0);
      tick();
    end
    total++;
    if (status_data !== 8'h04 || OUT !== 8'h10) begin
      bad++;
      $display("FAIL full_setup got OUT=%h st=%h want OUT=10 st=04", OUT, status_data);
    end
    drive(1'b1, PADDR, 8'h15, MEMORY_WRITE, 1'b1);
    tick();
    total++;
    if (status_data !== 8'h04 || OUT !== 8'h11 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_push_pop got OUT=%h v=%b st=%h want OUT=11 v=1 st=04",
               OUT, out_valid, status_data);
    end
    drive(1'b1, 8'h00, 8'h00, MEMORY_NOP, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({OUT, out_valid, status_data} !== {m_out, m_vld, m_status()}) begin
        bad++;
        $display("FAIL full_drain cyc=%0d got OUT=%h v=%b st=%h want OUT=%h v=%b st=%h",
                 i, OUT, out_valid, status_data, m_out, m_vld, m_status());
      end
    end
  endtask

  task automatic test_enable_reset();
    drive(1'b0, PADDR, 8'h77, MEMORY_WRITE, 1'b0);
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || status_data !== 8'h00) begin
      bad++;
      $display("FAIL enable_gate got v=%b st=%h want v=0 st=00", out_valid, status_data);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, PADDR, DEFAULT_TYPE'(8'h20 + i), MEMORY_WRITE, 1'b0);
      tick();
    end
    drive(1'b1, 8'h00, 8'h00, MEMORY_NOP, 1'b1);
    tick();
    total++;
    if (status_data !== 8'h02 || OUT !== 8'h21) begin
      bad++;
      $display("FAIL rst_setup got OUT=%h st=%h want OUT=21 st=02", OUT, status_data);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    total++;
    if (OUT !== 8'h00 || out_valid !== 1'b0 || status_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset got OUT=%h v=%b st=%h want OUT=00 v=0 st=00",
               OUT, out_valid, status_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (OUT !== 8'h00 || out_valid !== 1'b0 || status_data !== 8'h00) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got OUT=%h v=%b st=%h want OUT=00 v=0 st=00",
                 i, OUT, out_valid, status_data);
      end
    end
  endtask

  task automatic test_random();
    DEFAULT_TYPE a;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = PADDR;
        2:       a = SADDR;
        default: a = DEFAULT_TYPE'($urandom_range(0, 255));
      endcase
      drive(($urandom_range(0, 3) != 0), a, DEFAULT_TYPE'($urandom_range(0, 255)),
            MEMORY_FLAG_TYPE'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0));
      RESET = ($urandom_range(0, 63) == 0);
      tick();
      total++;
      if ({OUT, out_valid, status_data} !== {m_out, m_vld, m_status()}) begin
        bad++;
        $display("FAIL random cyc=%0d got OUT=%h v=%b st=%h want OUT=%h v=%b st=%h",
                 i, OUT, out_valid, status_data, m_out, m_vld, m_status());
      end
    end
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_overflow();
    test_full_push_pop();
    test_enable_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before completion");
    $fatal(1);
  end

endmodule
